// File: rtl/mac_feeder_pkg.sv
// Shared constants for the MAC feeder: FSM state encoding and the finish/watchdog timing.
package mac_feeder_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_RESP   = 3'd5;

  // The MAC pulses finish FIN_LAT cycles after the last operand; the watchdog allows WDOG_SLACK more.
  localparam int FIN_LAT    = 3;
  localparam int WDOG_SLACK = 3;

endpackage

// File: rtl/mac_feeder_buf.sv
// Operand-pair register file: one synchronous write port, one combinational read port.
module mac_feeder_buf
  import mac_feeder_pkg::*;
#(
  parameter int W     = 16,
  parameter int AW    = 5,
  parameter int DEPTH = 31
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/mac_feeder.sv
// Job driver for the pipelined MAC: buffers N operand pairs, streams them gap-free after a start
// pulse, and returns the job's dot product as a delta against the accumulator value at job start.
module mac_feeder
  import mac_feeder_pkg::*;
#(
  parameter int DW     = 8,
  parameter int OW     = 16,
  parameter int CW     = 5,
  parameter int MAXLEN = 31
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [CW-1:0] cmd_len,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [DW-1:0] op_a,
  input  logic [DW-1:0] op_b,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [OW-1:0] res_data,
  output logic          res_err,
  output logic          mac_start,
  output logic [CW-1:0] mac_count,
  output logic [DW-1:0] mac_opA,
  output logic [DW-1:0] mac_opB,
  input  logic          mac_finish,
  input  logic [OW-1:0] mac_out
);

  localparam logic [CW-1:0] ONE     = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [2:0]    WD_LAST = 3'(FIN_LAT + WDOG_SLACK - 1);

  logic [2:0]      state_q, state_d;
  logic [CW-1:0]   len_q, len_d;
  logic [CW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]   base_q, base_d;
  logic [OW-1:0]   res_data_q, res_data_d;
  logic            res_err_q, res_err_d;
  logic [2:0]      wd_q, wd_d;
  logic            buf_we;
  logic [2*DW-1:0] buf_rdata;

  mac_feeder_buf #(.W(2*DW), .AW(CW), .DEPTH(MAXLEN)) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_ptr_q),
    .wdata ({op_a, op_b}),
    .raddr (rd_ptr_q),
    .rdata (buf_rdata)
  );

  assign cmd_ready = (state_q == S_IDLE);
  assign op_ready  = (state_q == S_LOAD) && (wr_ptr_q < len_q);
  assign buf_we    = op_valid && op_ready;
  assign res_valid = (state_q == S_RESP);
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign mac_start = (state_q == S_START);
  assign mac_count = (state_q == S_START) ? len_q : '0;
  assign mac_opA   = (state_q == S_STREAM) ? buf_rdata[2*DW-1:DW] : '0;
  assign mac_opB   = (state_q == S_STREAM) ? buf_rdata[DW-1:0] : '0;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    base_d     = base_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    wd_d       = wd_q;
    case (state_q)
      S_IDLE: begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        if (cmd_valid) begin
          len_d  = cmd_len;
          base_d = mac_out;
          if (cmd_len == '0) begin
            // Zero-length job: the MAC would never finish, so answer directly.
            res_data_d = '0;
            res_err_d  = 1'b0;
            state_d    = S_RESP;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (buf_we) begin
          wr_ptr_d = wr_ptr_q + ONE;
          if (wr_ptr_q == len_q - ONE) state_d = S_START;
        end
      end
      S_START: begin
        rd_ptr_d = '0;
        wd_d     = '0;
        state_d  = S_STREAM;
      end
      S_STREAM: begin
        rd_ptr_d = rd_ptr_q + ONE;
        if (rd_ptr_q == len_q - ONE) begin
          wd_d    = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mac_finish) begin
          // Accumulator is never cleared; modular subtraction recovers this job's sum.
          res_data_d = mac_out - base_q;
          res_err_d  = 1'b0;
          state_d    = S_RESP;
        end else if (wd_q == WD_LAST) begin
          res_data_d = '0;
          res_err_d  = 1'b1;
          state_d    = S_RESP;
        end else begin
          wd_d = wd_q + 3'd1;
        end
      end
      S_RESP: begin
        if (res_ready) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wd_q       <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wd_q       <= wd_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
    end
  end

  always_ff @(posedge clk) begin
    len_q  <= len_d;
    base_q <= base_d;
  end

endmodule
